mem_sram_ctrl: RTL and testbench

Memory-stage SRAM controller that sits directly downstream of the execute stage, inside the memory stage in place of the on-chip data memory. It accepts one 32-bit load or store per transaction from the EXE/MEM pipeline register and performs it on a 16-bit asynchronous SRAM as two half-word accesses. While the transaction is in progress it drives `ready` low; the top level ORs `~ready` into the pipeline freeze.

---
 rtl/mem_sram_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_sram_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_ctrl.sv
// Purpose: memory-stage controller performing each 32-bit load/store as two half-word accesses on a 16-bit async SRAM.
// Latency: acceptance cycle + (WAIT_CYCLES+1) per half + one DONE cycle; ready is low from acceptance until DONE.
// Backpressure: ready drops combinationally with the request and the pipeline freezes until the single-cycle DONE pulse.
module mem_sram_ctrl #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;
    logic        op_wr_q;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic        req;
    logic        last_cyc;
    logic [16:0] word_in;
    logic        dq_oe;
    logic [15:0] dq_out;

    assign req      = rd_en | wr_en;
    assign last_cyc = (cnt_q == LAST_CNT);
    // Out-of-window addresses wrap silently into the 17-bit word space.
    assign word_in  = 17'((address - BASE_ADDR) >> 2);

    // The controller only drives the shared data bus during write accesses.
    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch the request at acceptance; a simultaneous rd/wr becomes a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_wr_q <= 1'b0;
            word_q  <= 17'd0;
            wdata_q <= 32'd0;
        end else if (state_q == S_IDLE && req) begin
            op_wr_q <= wr_en;
            word_q  <= word_in;
            wdata_q <= write_data;
        end
    end

    // Capture each read half on the final cycle of its access window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= 32'd0;
        end else if (!op_wr_q && last_cyc) begin
            if (state_q == S_LOW) begin
                read_data[15:0] <= SRAM_DQ;
            end else if (state_q == S_HIGH) begin
                read_data[31:16] <= SRAM_DQ;
            end
        end
    end

    // Next state: each half holds for WAIT_CYCLES+1 cycles, DONE for one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_LOW;
                    cnt_d   = 3'd0;
                end
            end
            S_LOW: begin
                if (last_cyc) begin
                    state_d = S_HIGH;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_HIGH: begin
                if (last_cyc) begin
                    state_d = S_DONE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes, address, bus drive and ready decoded from state and latched op.
    always_comb begin
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        SRAM_ADDR = 18'd0;
        dq_oe     = 1'b0;
        dq_out    = 16'd0;
        ready     = 1'b1;
        case (state_q)
            S_IDLE: begin
                ready = ~req;
            end
            S_LOW, S_HIGH: begin
                ready     = 1'b0;
                SRAM_CE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                SRAM_ADDR = {word_q, (state_q == S_HIGH)};
                if (op_wr_q) begin
                    SRAM_WE_N = 1'b0;
                    dq_oe     = 1'b1;
                    dq_out    = (state_q == S_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
                end else begin
                    SRAM_OE_N = 1'b0;
                end
            end
            default: begin
                ready = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: two instances (WAIT_CYCLES=1 and 0), each with its own async SRAM model.
// Expectations come from a word-level golden memory and the cycle-count rules of the controller.
// Directed steps followed by a randomized load/store mix.
module tb_mem_sram_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance with WAIT_CYCLES=1
    logic        rd1, wr1;
    logic [31:0] a1, d1;
    wire  [31:0] rdata1;
    wire         ready1;
    wire  [15:0] dq1;
    wire  [17:0] sa1;
    wire         we1, oe1, ce1, ub1, lb1;

    // Instance with WAIT_CYCLES=0
    logic        rd0, wr0;
    logic [31:0] a0, d0;
    wire  [31:0] rdata0;
    wire         ready0;
    wire  [15:0] dq0;
    wire  [17:0] sa0;
    wire         we0, oe0, ce0, ub0, lb0;

    mem_sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) u_w1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(a1), .write_data(d1),
        .read_data(rdata1), .ready(ready1), .SRAM_DQ(dq1), .SRAM_ADDR(sa1),
        .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
    );

    mem_sram_ctrl #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) u_w0 (
        .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0), .address(a0), .write_data(d0),
        .read_data(rdata0), .ready(ready0), .SRAM_DQ(dq0), .SRAM_ADDR(sa0),
        .SRAM_WE_N(we0), .SRAM_OE_N(oe0), .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
    );

    // Asynchronous SRAM models with a preload port
    logic [15:0] m1 [0:262143];
    logic [15:0] m0 [0:262143];
    logic        pl_we = 1'b0;
    logic        pl_s  = 1'b0;
    logic [17:0] pl_a  = 18'd0;
    logic [15:0] pl_d  = 16'd0;

    assign dq1 = (!ce1 && !oe1 && we1) ? m1[sa1] : 16'hzzzz;
    assign dq0 = (!ce0 && !oe0 && we0) ? m0[sa0] : 16'hzzzz;

    always @(posedge clk) begin
        if (pl_we && !pl_s) begin
            m1[pl_a] <= pl_d;
        end else if (!ce1 && !we1) begin
            if (!lb1) m1[sa1][7:0]  <= dq1[7:0];
            if (!ub1) m1[sa1][15:8] <= dq1[15:8];
        end
    end

    always @(posedge clk) begin
        if (pl_we && pl_s) begin
            m0[pl_a] <= pl_d;
        end else if (!ce0 && !we0) begin
            if (!lb0) m0[sa0][7:0]  <= dq0[7:0];
            if (!ub0) m0[sa0][15:8] <= dq0[15:8];
        end
    end

    // Observation mux: z0 selects the WAIT_CYCLES=0 instance
    logic        z0 = 1'b0;
    wire         o_ready = z0 ? ready0 : ready1;
    wire  [31:0] o_rdata = z0 ? rdata0 : rdata1;
    wire  [17:0] o_addr  = z0 ? sa0 : sa1;
    wire         o_we    = z0 ? we0 : we1;
    wire         o_oe    = z0 ? oe0 : oe1;
    wire         o_ce    = z0 ? ce0 : ce1;

    // Reference model: word-level golden memory and last value loaded per instance
    logic [31:0] gold [int];
    logic [31:0] lastrd [2];
    logic [31:0] wq [$];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input bit s, input logic [17:0] a, input logic [15:0] d);
        pl_s  = s;
        pl_a  = a;
        pl_d  = d;
        pl_we = 1'b1;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    function automatic logic [16:0] word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - 32'd1024) >> 2;
        return off[16:0];
    endfunction

    function automatic int key_of(input bit s, input logic [31:0] addr);
        return int'({s, word_of(addr)});
    endfunction

    // One complete transaction, checked against cycle-count rules and the golden memory
    task automatic txn(input bit s, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data, input bit keep);
        int          wt;
        int          cnt;
        int          wel;
        int          oel;
        bit          seen;
        logic [16:0] w;
        logic [17:0] a_first;
        logic [17:0] a_last;
        logic [15:0] lo;
        logic [15:0] hi;
        bit          is_wr;
        wt      = s ? 0 : 1;
        w       = word_of(addr);
        is_wr   = wr;
        a_first = 18'd0;
        a_last  = 18'd0;
        @(negedge clk);
        z0 = s;
        if (s) begin rd0 = rd; wr0 = wr; a0 = addr; d0 = data; end
        else   begin rd1 = rd; wr1 = wr; a1 = addr; d1 = data; end
        #1;
        chk("accept_ready_low", {31'd0, o_ready}, 32'd0);
        chk("accept_ce_idle", {31'd0, o_ce}, 32'd1);
        cnt  = 1;
        wel  = 0;
        oel  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_ready) begin
                seen = 1'b1;
                break;
            end
            cnt++;
            if (!o_we) wel++;
            if (!o_oe) oel++;
            if (i == 0) a_first = o_addr;
            a_last = o_addr;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("ready_low_cycles", cnt, 2 * wt + 3);
        chk("we_low_cycles", wel, is_wr ? 2 * (wt + 1) : 0);
        chk("oe_low_cycles", oel, is_wr ? 0 : 2 * (wt + 1));
        chk("addr_low_half", {14'd0, a_first}, {14'd0, w, 1'b0});
        chk("addr_high_half", {14'd0, a_last}, {14'd0, w, 1'b1});
        chk("done_strobes_off", {29'd0, o_ce, o_we, o_oe}, 32'd7);
        if (is_wr) begin
            gold[key_of(s, addr)] = data;
            lo = s ? m0[{w, 1'b0}] : m1[{w, 1'b0}];
            hi = s ? m0[{w, 1'b1}] : m1[{w, 1'b1}];
            chk("sram_contents", {hi, lo}, data);
        end else begin
            lastrd[s] = gold[key_of(s, addr)];
        end
        chk("read_data", o_rdata, lastrd[s]);
        if (!keep) begin
            if (s) begin rd0 = 1'b0; wr0 = 1'b0; end
            else   begin rd1 = 1'b0; wr1 = 1'b0; end
        end
    endtask

    initial begin
        int          cnt;
        bit          seen;
        logic [31:0] ra;
        logic [31:0] rdt;
        bit          do_wr;

        rst = 1'b0;
        rd1 = 1'b1; wr1 = 1'b0; a1 = 32'd1024; d1 = 32'd0;
        rd0 = 1'b0; wr0 = 1'b0; a0 = 32'd0;    d0 = 32'd0;
        lastrd[0] = 32'd0;
        lastrd[1] = 32'd0;

        // Reset held with a pending read: strobes idle, read_data cleared
        #12;
        chk("rst_strobes", {27'd0, ce1, oe1, we1, ub1, lb1}, 32'h1F);
        chk("rst_addr", {14'd0, sa1}, 32'd0);
        chk("rst_read_data", rdata1, 32'd0);

        preload(1'b0, 18'd0, 16'h5678);
        preload(1'b0, 18'd1, 16'h1234);
        gold[key_of(1'b0, 32'd1024)] = 32'h12345678;
        preload(1'b1, 18'h3FFFE, 16'hA5A5);
        preload(1'b1, 18'h3FFFF, 16'h5A5A);
        gold[key_of(1'b1, 32'd1020)] = 32'h5A5AA5A5;
        chk("rst_held_read_data", rdata1, 32'd0);

        // Release reset with the read still requested: it starts on the first edge
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_oe_low", {31'd0, oe1}, 32'd0);
        cnt  = 1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready1) begin
                seen = 1'b1;
                break;
            end
            cnt++;
        end
        chk("post_rst_done_seen", {31'd0, seen}, 32'd1);
        chk("post_rst_busy_cycles", cnt, 4);
        chk("post_rst_read_data", rdata1, 32'h12345678);
        lastrd[0] = 32'h12345678;
        rd1 = 1'b0;

        // Directed read, write, read-back
        txn(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0);
        txn(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0);
        chk("sram_half4", {16'd0, m1[4]}, 32'h0000BEEF);
        chk("sram_half5", {16'd0, m1[5]}, 32'h0000DEAD);
        txn(1'b0, 1'b1, 1'b0, 32'd1032, 32'd0, 1'b0);

        // Back-to-back requests, then a simultaneous rd/wr that must write
        txn(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b1);
        txn(1'b0, 1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 1'b1);
        txn(1'b0, 1'b1, 1'b0, 32'd1040, 32'd0, 1'b1);
        txn(1'b0, 1'b1, 1'b1, 32'd1044, 32'h0BADF00D, 1'b0);
        txn(1'b0, 1'b1, 1'b0, 32'd1044, 32'd0, 1'b0);

        // Reset during the high half of a read
        @(negedge clk);
        z0 = 1'b0;
        rd1 = 1'b1; a1 = 32'd1024;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_high_addr", {14'd0, sa1}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_strobes", {27'd0, ce1, oe1, we1, ub1, lb1}, 32'h1F);
        chk("mid_rst_addr", {14'd0, sa1}, 32'd0);
        chk("mid_rst_read_data", rdata1, 32'd0);
        lastrd[0] = 32'd0;
        lastrd[1] = 32'd0;
        @(negedge clk);
        rd1 = 1'b0;
        rst = 1'b1;
        txn(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b0);

        // Zero wait states with an address below the window wrapping to the top
        txn(1'b1, 1'b1, 1'b0, 32'd1020, 32'd0, 1'b0);

        // Randomized stores and loads, including arbitrary addresses that wrap
        for (int n = 0; n < 24; n++) begin
            do_wr = (wq.size() == 0) || ($urandom_range(0, 1) == 1);
            if (do_wr) begin
                ra  = $urandom() & 32'hFFFF_FFFC;
                rdt = $urandom();
                wq.push_back(ra);
                txn(1'b0, 1'b0, 1'b1, ra, rdt, 1'b0);
            end else begin
                ra = wq[$urandom_range(0, wq.size() - 1)];
                txn(1'b0, 1'b1, 1'b0, ra, 32'd0, 1'b0);
            end
        end
        for (int n = 0; n < 4; n++) begin
            ra  = 32'd1024 + 32'($urandom_range(0, 15)) * 32'd4;
            rdt = $urandom();
            txn(1'b1, 1'b0, 1'b1, ra, rdt, 1'b0);
            txn(1'b1, 1'b1, 1'b0, ra, 32'd0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
